mu0_mem_loader: RTL and testbench
=================================

# mu0_mem_loader

Program memory and boot loader for the MU0 CPU. Holds a 4096×16 memory with one write/read port and one read-only port, matching the CPU's memory bus: address, address2, write, writedata, readdata and readdata2. After reset it holds the CPU in reset while a byte stream (length header followed by words) fills memory from address 0. It then releases the CPU and serves its accesses.

## Interface
Parameters:
- ADDR_W, 12, word address width
- DATA_W, 16, word width
- DEPTH, 4096, words of storage (= 2**ADDR_W)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  8  loader byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte; transfer when in_valid && in_ready
- cpu_rst  out  1  reset to CPU; high until load complete
- load_done  out  1  high in RUN
- load_err  out  1  high in ERROR
- cpu_address  in  ADDR_W  port A address
- cpu_address2  in  ADDR_W  port B address (read-only)
- cpu_read  in  1  accepted, not used for gating
- cpu_write  in  1  port A write enable
- cpu_writedata  in  DATA_W  port A write data
- cpu_readdata  out  DATA_W  port A read data
- cpu_readdata2  out  DATA_W  port B read data

## Operation
- Stream format: LEN_HI, LEN_LO (N = 16-bit word count, big-endian), then N words of two bytes each, high byte first. Words are written to addresses 0..N-1.
- FSM states: LEN_HI, LEN_LO, DATA_HI, DATA_LO, RUN, ERROR.
  - LEN_HI -> LEN_LO on a byte.
  - LEN_LO -> on a byte:
    - N==0 -> RUN
    - N>DEPTH -> ERROR
    - otherwise DATA_HI
  - DATA_HI -> DATA_LO on a byte; the byte is latched as the high byte.
  - DATA_LO -> on a byte, writes mem[waddr] <= {hi, byte}, increments waddr and decrements the remaining count. Goes to RUN if the remaining count reaches 0, else DATA_HI.
  - RUN and ERROR are terminal until rst.
- in_ready: 1 in LEN_HI..DATA_LO, 0 in RUN and ERROR, and 0 while rst is high.
- cpu_rst = 1 in every state except RUN.
- CPU writes are ignored unless the state is RUN. In RUN, loader writes never occur.
- Reads run on both ports every cycle in all states: cpu_readdata <= mem[cpu_address] and cpu_readdata2 <= mem[cpu_address2].
- Same-address write and read on the same edge returns old data (read-first) on both ports.
- N = DEPTH exactly is legal and fills memory with waddr wrapping to 0. N = DEPTH+1 goes to ERROR.

## Timing
- Reset values: state LEN_HI, waddr 0, count 0, cpu_rst 1, load_done 0, load_err 0, cpu_readdata 0, cpu_readdata2 0. Memory contents are not cleared.
- Read latency is 1 cycle: an address presented before edge k is visible on readdata after edge k. This matches the CPU's ADDR/DATA state pairs.
- Write takes effect at the edge where cpu_write=1. It is visible on a read presented in the next cycle.
- Release: the edge accepting the final byte (or LEN_LO with N==0) enters RUN. cpu_rst is low from that cycle, so the CPU sees its final reset edge at that same edge.
- rst mid-load: returns to LEN_HI next cycle. Already-written words remain, waddr restarts at 0, and a fresh stream is required.
- rst in RUN: cpu_rst rises the cycle after rst and memory is retained. The host must resend at least a header.
- in_valid without in_ready: the byte is held by the source and not consumed.

## Structure
- mu0_pkg: ADDR_W/DATA_W constants, the shared opcode_t enum (used by CPU and test benches), and loader_state_t.
- Sub-module mu0_dpram: 1 write / 2 read-first registered read ports, parameterised ADDR_W/DATA_W. The loader FSM and write-port mux live in mu0_mem_loader.

## Test plan
- Bytes 00 03 00 05 70 00 12 34 with in_valid held high:
  - in_ready low after the 8th byte, load_done=1 and cpu_rst falls on that edge.
  - Reading mem 0..2 gives 0005, 7000, 1234.
- Bytes 00 00 -> RUN on the 2nd byte; no memory writes.
- Bytes 10 01 -> load_err=1, in_ready=0, cpu_rst held high indefinitely; rst returns to LEN_HI.
- Test 1 repeated with random in_valid gaps -> identical memory image and release after the same byte count.
- After test 1, drive cpu_address=2 and cpu_address2=0 -> next cycle readdata=1234 and readdata2=0005.
  - Then write 0xBEEF to address 2 with the same-cycle read of 2 -> old 1234, then BEEF the following cycle.
- rst after 3 bytes, then a full test 1 stream -> correct image and a single release. A CPU write during load (cpu_write=1, address 0) is ignored.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: bus widths, instruction opcodes and boot-loader FSM states.
package mu0_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_STA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_JMP = 4'h4,
    OP_JGE = 4'h5,
    OP_JNE = 4'h6,
    OP_STP = 4'h7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/mu0_dpram.sv
// One write port plus two registered read-first read ports over a 2**ADDR_W word array.
module mu0_dpram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never cleared so a warm reset keeps the loaded program.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads sample the array before this edge's write lands, giving old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/mu0_mem_loader.sv
// MU0 program memory with a byte-stream boot loader that holds the CPU in reset until loaded.
module mu0_mem_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [ADDR_W-1:0] cpu_address2,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic [DATA_W-1:0] cpu_readdata2
);

  import mu0_pkg::*;

  loader_state_t     state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_word;
  logic              loading;
  logic              accept;
  logic              ld_we;
  logic              run;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused_cpu_read;

  // The CPU's read strobe carries no information: both ports read every cycle.
  assign unused_cpu_read = cpu_read;

  assign loading  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                    (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO);
  assign in_ready = !rst && loading;
  assign accept   = in_valid && in_ready;
  assign len_word = LEN_W'({hi_q, in_data});
  assign run      = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LEN_HI;
      hi_q      <= '0;
      waddr_q   <= '0;
      count_q   <= '0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      waddr_q   <= waddr_d;
      count_q   <= count_d;
      cpu_rst   <= (state_d != ST_RUN);
      load_done <= (state_d == ST_RUN);
      load_err  <= (state_d == ST_ERROR);
    end
  end

  // Loader sequencing; hi_q doubles as the length high byte and the data high byte.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    waddr_d = waddr_q;
    count_d = count_q;
    ld_we   = 1'b0;
    unique case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          count_d = len_word;
          waddr_d = '0;
          if (len_word == '0) begin
            state_d = ST_RUN;
          end else if ((LEN_W + 1)'(len_word) > (LEN_W + 1)'(DEPTH)) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          ld_we   = 1'b1;
          waddr_d = waddr_q + ADDR_W'(1);
          count_d = count_q - LEN_W'(1);
          state_d = (count_q == LEN_W'(1)) ? ST_RUN : ST_DATA_HI;
        end
      end
      default: begin
      end
    endcase
  end

  // Port A write ownership: loader until RUN, CPU afterwards.
  assign mem_we    = !rst && (run ? cpu_write : ld_we);
  assign mem_waddr = run ? cpu_address : waddr_q;
  assign mem_wdata = run ? cpu_writedata : DATA_W'({hi_q, in_data});

  mu0_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dpram (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (cpu_address),
    .raddr_b (cpu_address2),
    .rdata_a (cpu_readdata),
    .rdata_b (cpu_readdata2)
  );

endmodule

// File: tb/tb_mu0_mem_loader.sv
// Scoreboard bench for mu0_mem_loader: streams load images, then checks release and both read ports.
module tb_mu0_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  logic [11:0] cpu_address;
  logic [11:0] cpu_address2;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_writedata;
  logic [15:0] cpu_readdata;
  logic [15:0] cpu_readdata2;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [4096];
  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];
  logic [7:0]  stream [$];

  always #5 clk = ~clk;

  mu0_mem_loader #(
    .ADDR_W (12),
    .DATA_W (16),
    .DEPTH  (4096)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .cpu_rst       (cpu_rst),
    .load_done     (load_done),
    .load_err      (load_err),
    .cpu_address   (cpu_address),
    .cpu_address2  (cpu_address2),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_readdata2 (cpu_readdata2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    cpu_write = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_cpu_rst", 32'(cpu_rst), 32'(1));
    check("rst_load_done", 32'(load_done), 32'(0));
    check("rst_load_err", 32'(load_err), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  // Header plus model[0..n-1], high byte first.
  task automatic build_stream(input int n);
    logic [15:0] len;
    len = 16'(n);
    stream.delete();
    stream.push_back(len[15:8]);
    stream.push_back(len[7:0]);
    for (int i = 0; i < n; i++) begin
      stream.push_back(model[i][15:8]);
      stream.push_back(model[i][7:0]);
    end
  endtask

  task automatic send_stream(input int max_gap, input bit exp_run, input bit exp_err);
    for (int i = 0; i < stream.size(); i++) begin
      int gap;
      int t;
      bit last;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'(1));
      @(negedge clk);
      last = (i == stream.size() - 1);
      check("cpu_rst", 32'(cpu_rst), 32'(!(last && exp_run)));
      check("load_done", 32'(load_done), 32'(last && exp_run));
      check("load_err", 32'(load_err), 32'(last && exp_err));
    end
    in_valid = 1'b0;
  endtask

  // Port A walks up from base, port B walks down; expectations queued at issue, popped a cycle later.
  task automatic read_range(input logic [11:0] base, input int n);
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        check("rd_a", 32'(cpu_readdata), 32'(exp_a.pop_front()));
        check("rd_b", 32'(cpu_readdata2), 32'(exp_b.pop_front()));
      end
      if (i < n) begin
        cpu_address  = base + 12'(i);
        cpu_address2 = base + 12'(n - 1 - i);
        exp_a.push_back(model[cpu_address]);
        exp_b.push_back(model[cpu_address2]);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    cpu_address   = '0;
    cpu_address2  = '0;
    cpu_read      = 1'b1;
    cpu_write     = 1'b0;
    cpu_writedata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_readdata", 32'(cpu_readdata), 32'(0));
    check("reset_readdata2", 32'(cpu_readdata2), 32'(0));
    do_reset();

    // Basic 3-word image with in_valid held high.
    model[0] = 16'h0005;
    model[1] = 16'h7000;
    model[2] = 16'h1234;
    build_stream(3);
    send_stream(0, 1'b1, 1'b0);
    check("run_in_ready", 32'(in_ready), 32'(0));
    read_range(12'd0, 3);

    // Dual-port read, then read-first write on port A.
    cpu_address  = 12'd2;
    cpu_address2 = 12'd0;
    exp_a.push_back(model[2]);
    exp_b.push_back(model[0]);
    @(negedge clk);
    check("dual_rd_a", 32'(cpu_readdata), 32'(exp_a.pop_front()));
    check("dual_rd_b", 32'(cpu_readdata2), 32'(exp_b.pop_front()));
    cpu_address2  = 12'd2;
    cpu_write     = 1'b1;
    cpu_writedata = 16'hBEEF;
    exp_a.push_back(model[2]);
    exp_b.push_back(model[2]);
    model[2] = 16'hBEEF;
    @(negedge clk);
    cpu_write = 1'b0;
    check("rf_old_a", 32'(cpu_readdata), 32'(exp_a.pop_front()));
    check("rf_old_b", 32'(cpu_readdata2), 32'(exp_b.pop_front()));
    exp_a.push_back(model[2]);
    exp_b.push_back(model[2]);
    @(negedge clk);
    check("rf_new_a", 32'(cpu_readdata), 32'(exp_a.pop_front()));
    check("rf_new_b", 32'(cpu_readdata2), 32'(exp_b.pop_front()));

    // Reset in RUN, abort a partial load, then reload with gaps while the CPU tries to write.
    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h03);
    stream.push_back(8'h00);
    send_stream(0, 1'b0, 1'b0);
    do_reset();
    cpu_address   = 12'd0;
    cpu_address2  = 12'd1;
    cpu_write     = 1'b1;
    cpu_writedata = 16'hDEAD;
    model[2] = 16'h1234;
    build_stream(3);
    send_stream(3, 1'b1, 1'b0);
    cpu_write = 1'b0;
    read_range(12'd0, 3);

    // Empty image releases on the second header byte and writes nothing.
    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    send_stream(0, 1'b1, 1'b0);
    read_range(12'd0, 3);

    // DEPTH+1 words is rejected and holds the CPU in reset.
    do_reset();
    stream.delete();
    stream.push_back(8'h10);
    stream.push_back(8'h01);
    send_stream(0, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (20) @(negedge clk);
    check("err_in_ready", 32'(in_ready), 32'(0));
    check("err_cpu_rst", 32'(cpu_rst), 32'(1));
    check("err_load_err", 32'(load_err), 32'(1));
    in_valid = 1'b0;
    do_reset();
    check("err_cleared", 32'(load_err), 32'(0));

    // Exactly DEPTH words fills the whole array.
    for (int i = 0; i < 4096; i++) model[i] = 16'(i * 40503 + 7);
    build_stream(4096);
    send_stream(0, 1'b1, 1'b0);
    read_range(12'd0, 3);
    read_range(12'd4094, 2);
    read_range(12'd2047, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
